// File: rtl/elevator_request_sequencer_if.sv
// Command link between the request sequencer and the elevator controller.
// The sequencer drives mode/request; the controller reports its run state
// and whether a LIST scan is still in progress.
interface elevator_request_sequencer_if;
    logic [1:0] mode;
    logic [3:0] request;
    logic       elevState;
    logic       listBusy;

    modport master (output mode, output request, input elevState, input listBusy);
    modport slave  (input mode, input request, output elevState, output listBusy);
endinterface

// File: rtl/elevator_request_sequencer.sv
// Front end for the elevator controller: debounces the floor call/cancel
// buttons and the GO/LIST buttons, latches each press as a pending event,
// and feeds the events one at a time into the controller's mode/request
// command port whenever the controller is able to accept them.
module elevator_request_sequencer #(
    parameter int FLOORS = 15,
    parameter int DEB    = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [FLOORS-1:0]             callBtn,
    input  logic [FLOORS-1:0]             cancelBtn,
    input  logic                          goBtn,
    input  logic                          listBtn,
    elevator_request_sequencer_if.master  ctrl,
    output logic [FLOORS-1:0]             pendCall,
    output logic [FLOORS-1:0]             pendCancel,
    output logic                          seqBusy
);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_LIST = 2'b01;
    localparam logic [1:0] MODE_DEL  = 2'b10;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    // All buttons share one debounce array: calls, cancels, go, list.
    localparam int         NB      = 2 * FLOORS + 2;
    localparam logic [2:0] DEB_MAX = 3'(DEB);
    localparam logic [2:0] DEB_PRE = 3'(DEB - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, LIST, RUN} state_t;

    state_t            state, stateNext;
    logic [NB-1:0]     btnRaw, btnEv;
    logic [2:0]        debCnt [NB];
    logic [FLOORS-1:0] callEv, cancelEv;
    logic              goEv, listEv;
    logic              goFlag, listFlag;
    logic [1:0]        modeNext;
    logic [3:0]        reqNext;
    logic [FLOORS-1:0] clrCall, clrCancel;
    logic              clrGo, clrList;

    // Floor code (1-based) of the lowest set bit, 0 when nothing is set.
    function automatic logic [3:0] lowest_code(input logic [FLOORS-1:0] v);
        lowest_code = 4'd0;
        for (int i = FLOORS - 1; i >= 0; i--)
            if (v[i]) lowest_code = 4'(i + 1);
    endfunction

    // One-hot mask of the lowest set bit, all zero when nothing is set.
    function automatic logic [FLOORS-1:0] lowest_mask(input logic [FLOORS-1:0] v);
        lowest_mask = '0;
        for (int i = FLOORS - 1; i >= 0; i--)
            if (v[i]) begin
                lowest_mask    = '0;
                lowest_mask[i] = 1'b1;
            end
    endfunction

    assign btnRaw   = {listBtn, goBtn, cancelBtn, callBtn};
    assign callEv   = btnEv[FLOORS-1:0];
    assign cancelEv = btnEv[2*FLOORS-1:FLOORS];
    assign goEv     = btnEv[2*FLOORS];
    assign listEv   = btnEv[2*FLOORS+1];

    // A press fires on the edge where its counter climbs from DEB-1 to DEB.
    always_comb begin
        btnEv = '0;
        for (int i = 0; i < NB; i++)
            btnEv[i] = btnRaw[i] && (debCnt[i] == DEB_PRE);
    end

    // Saturating debounce counters; a low sample restarts the count.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (RST || !btnRaw[i])
                debCnt[i] <= 3'd0;
            else if (debCnt[i] != DEB_MAX)
                debCnt[i] <= debCnt[i] + 3'd1;
        end
    end

    // Command selection and FSM next state; outputs default to NOP.
    always_comb begin
        stateNext = state;
        modeNext  = MODE_ADD;
        reqNext   = 4'd0;
        clrCall   = '0;
        clrCancel = '0;
        clrGo     = 1'b0;
        clrList   = 1'b0;
        case (state)
            IDLE: begin
                if (!ctrl.elevState) begin
                    if (|pendCancel) begin
                        modeNext  = MODE_DEL;
                        reqNext   = lowest_code(pendCancel);
                        clrCancel = lowest_mask(pendCancel);
                        stateNext = ISSUE;
                    end else if (|pendCall) begin
                        modeNext  = MODE_ADD;
                        reqNext   = lowest_code(pendCall);
                        clrCall   = lowest_mask(pendCall);
                        stateNext = ISSUE;
                    end else if (listFlag) begin
                        modeNext  = MODE_LIST;
                        clrList   = 1'b1;
                        stateNext = LIST;
                    end else if (goFlag) begin
                        modeNext  = MODE_RUN;
                        clrGo     = 1'b1;
                        stateNext = ISSUE;
                    end
                end
            end
            // The registered command has been shown for one cycle; a run
            // command hands over to RUN, anything else returns to IDLE.
            ISSUE: stateNext = (ctrl.mode == MODE_RUN) ? RUN : IDLE;
            LIST: begin
                if (ctrl.listBusy) modeNext  = MODE_LIST;
                else               stateNext = IDLE;
            end
            RUN: if (!ctrl.elevState) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, registered command outputs and pending-event bookkeeping.
    // Fresh events are applied after the selection clear so a press landing
    // on the issuing edge is not lost; cancel always beats call.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            ctrl.mode    <= MODE_ADD;
            ctrl.request <= 4'd0;
            pendCall     <= '0;
            pendCancel   <= '0;
            goFlag       <= 1'b0;
            listFlag     <= 1'b0;
        end else begin
            state        <= stateNext;
            ctrl.mode    <= modeNext;
            ctrl.request <= reqNext;
            pendCancel   <= (pendCancel & ~clrCancel) | cancelEv;
            pendCall     <= ((pendCall & ~clrCall) | callEv) & ~cancelEv;
            goFlag       <= (goFlag & ~clrGo) | goEv;
            listFlag     <= (listFlag & ~clrList) | listEv;
        end
    end

    assign seqBusy = (state != IDLE) || (|pendCall) || (|pendCancel) || goFlag || listFlag;

endmodule

// File: tb/tb_elevator_request_sequencer.sv
// Bench for elevator_request_sequencer: fixed vector table, hand-written
// held-button and reset-during-LIST sequences, then random stimulus against
// an event-level reference model.
module tb_elevator_request_sequencer;

    localparam int DEB = 2;

    logic        CLK;
    logic        RST;
    logic [14:0] callBtn, cancelBtn;
    logic        goBtn, listBtn;
    logic [14:0] pendCall, pendCancel;
    logic        seqBusy;

    int checks = 0;
    int errors = 0;

    elevator_request_sequencer_if bus ();

    elevator_request_sequencer #(.FLOORS(15), .DEB(DEB)) dut (
        .CLK(CLK), .RST(RST), .callBtn(callBtn), .cancelBtn(cancelBtn),
        .goBtn(goBtn), .listBtn(listBtn), .ctrl(bus),
        .pendCall(pendCall), .pendCancel(pendCancel), .seqBusy(seqBusy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [14:0] c;
        logic [14:0] x;
        logic        g, l, e, b;
        logic [1:0]  m;
        logic [3:0]  q;
        logic [14:0] pc, px;
        logic        sb;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t row(input logic [14:0] c, input logic [14:0] x,
                                 input logic g, input logic l, input logic e, input logic b,
                                 input logic [1:0] m, input logic [3:0] q,
                                 input logic [14:0] pc, input logic [14:0] px, input logic sb);
        vec_t v;
        v.c = c; v.x = x; v.g = g; v.l = l; v.e = e; v.b = b;
        v.m = m; v.q = q; v.pc = pc; v.px = px; v.sb = sb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buttons tracked as run lengths of high samples,
    // pending work as plain bit sets, the command stream as a few phases.
    logic [14:0] mCall, mCancel;
    logic        mGo, mList;
    logic        nopDue, runAfter, listing, running;
    logic [1:0]  mMode;
    logic [3:0]  mReq;
    int          runLen [32];

    function automatic int first_set(input logic [14:0] v);
        for (int i = 0; i < 15; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic [14:0] c, input logic [14:0] x,
                                input logic g, input logic l, input logic e, input logic b);
        logic [31:0] raw, ev;
        int f;
        if (r) begin
            mCall = '0; mCancel = '0; mGo = 0; mList = 0;
            nopDue = 0; runAfter = 0; listing = 0; running = 0;
            mMode = 2'd0; mReq = 4'd0;
            for (int i = 0; i < 32; i++) runLen[i] = 0;
            return;
        end
        mMode = 2'd0;
        mReq  = 4'd0;
        if (listing) begin
            if (b) mMode = 2'd1; else listing = 0;
        end else if (nopDue) begin
            nopDue = 0; running = runAfter; runAfter = 0;
        end else if (running) begin
            if (!e) running = 0;
        end else if (!e) begin
            f = first_set(mCancel);
            if (f >= 0) begin
                mMode = 2'd2; mReq = 4'(f + 1); mCancel[f] = 1'b0; nopDue = 1;
            end else begin
                f = first_set(mCall);
                if (f >= 0) begin
                    mMode = 2'd0; mReq = 4'(f + 1); mCall[f] = 1'b0; nopDue = 1;
                end else if (mList) begin
                    mMode = 2'd1; mList = 0; listing = 1;
                end else if (mGo) begin
                    mMode = 2'd3; mGo = 0; nopDue = 1; runAfter = 1;
                end
            end
        end
        raw = {l, g, x, c};
        ev  = '0;
        for (int i = 0; i < 32; i++) begin
            if (raw[i]) begin
                runLen[i]++;
                ev[i] = (runLen[i] == DEB);
            end else begin
                runLen[i] = 0;
            end
        end
        mCancel = mCancel | ev[29:15];
        mCall   = (mCall | ev[14:0]) & ~ev[29:15];
        if (ev[30]) mGo = 1;
        if (ev[31]) mList = 1;
    endtask

    function automatic logic model_busy();
        return listing | nopDue | running | (|mCall) | (|mCancel) | mGo | mList;
    endfunction

    // Drive one cycle of inputs, let the edge happen, settle at the negedge.
    task automatic step(input logic r, input logic [14:0] c, input logic [14:0] x,
                        input logic g, input logic l, input logic e, input logic b);
        RST = r; callBtn = c; cancelBtn = x; goBtn = g; listBtn = l;
        bus.elevState = e; bus.listBusy = b;
        @(posedge CLK);
        model_update(r, c, x, g, l, e, b);
        @(negedge CLK);
    endtask

    initial begin
        logic [14:0] rc, rx;
        logic        rg, rl, re, rb, rr;

        RST = 1'b1; callBtn = '0; cancelBtn = '0; goBtn = 1'b0; listBtn = 1'b0;
        bus.elevState = 1'b0; bus.listBusy = 1'b0;

        // Vector table: c, x, go, list, elevState, listBusy | mode, req, pendCall, pendCancel, seqBusy
        vq.push_back(row(15'h0004, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0004, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0004, 15'h0, 1'b1));
        vq.push_back(row(15'h0004, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0010, 15'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0000, 1'b0));
        vq.push_back(row(15'h0010, 15'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0010, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd5, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0042, 15'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0042, 15'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0042, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 15'h0040, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0040, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd7, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0100, 15'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0100, 15'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 15'h0100, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 15'h0100, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0100, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd9, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 15'h0000, 15'h0, 1'b1));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));
        vq.push_back(row(15'h0000, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 15'h0000, 15'h0, 1'b0));

        @(negedge CLK);
        step(1'b1, 15'h7fff, 15'h7fff, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_mode", bus.mode, 2'd0);
        chk("reset_request", bus.request, 4'd0);
        chk("reset_pendCall", pendCall, 15'h0);
        chk("reset_pendCancel", pendCancel, 15'h0);
        chk("reset_seqBusy", seqBusy, 1'b0);

        foreach (vq[i]) begin
            step(1'b0, vq[i].c, vq[i].x, vq[i].g, vq[i].l, vq[i].e, vq[i].b);
            chk($sformatf("vec%0d_mode", i), bus.mode, vq[i].m);
            chk($sformatf("vec%0d_request", i), bus.request, vq[i].q);
            chk($sformatf("vec%0d_pendCall", i), pendCall, vq[i].pc);
            chk($sformatf("vec%0d_pendCancel", i), pendCancel, vq[i].px);
            chk($sformatf("vec%0d_seqBusy", i), seqBusy, vq[i].sb);
        end

        // Held call button: one event, one command, no re-fire while held.
        step(1'b0, 15'h0001, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 15'h0001, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_latched", pendCall, 15'h0001);
        step(1'b0, 15'h0001, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_issue_req", bus.request, 4'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 15'h0001, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("hold%0d_pendCall", k), pendCall, 15'h0);
            chk($sformatf("hold%0d_request", k), bus.request, 4'd0);
        end
        step(1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted while LIST is active with calls pending.
        step(1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("list_enter_mode", bus.mode, 2'd1);
        step(1'b0, 15'h0011, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 15'h0011, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("list_hold_mode", bus.mode, 2'd1);
        chk("list_pendCall", pendCall, 15'h0011);
        step(1'b1, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rstlist_mode", bus.mode, 2'd0);
        chk("rstlist_request", bus.request, 4'd0);
        chk("rstlist_pendCall", pendCall, 15'h0);
        chk("rstlist_seqBusy", seqBusy, 1'b0);
        step(1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("postrst_mode", bus.mode, 2'd0);
        chk("postrst_seqBusy", seqBusy, 1'b0);

        // Random traffic against the reference model.
        step(1'b1, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rc = '0; rx = '0; rg = 0; rl = 0; re = 0; rb = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) rc = 15'($urandom & $urandom & $urandom);
            if ($urandom_range(7) == 0) rx = 15'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(9) == 0) rg = ~rg;
            if ($urandom_range(11) == 0) rl = ~rl;
            if ($urandom_range(7) == 0) re = ~re;
            rb = ($urandom_range(2) != 0);
            rr = ($urandom_range(299) == 0);
            step(rr, rc, rx, rg, rl, re, rb);
            chk("rnd_mode", bus.mode, mMode);
            chk("rnd_request", bus.request, mReq);
            chk("rnd_pendCall", pendCall, mCall);
            chk("rnd_pendCancel", pendCancel, mCancel);
            chk("rnd_seqBusy", seqBusy, model_busy());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
